soc_system_onchip_memory_burst: RTL
===================================

# soc_system_onchip_memory_burst

Parametrised on-chip RAM with an Avalon-MM burst slave, registered read data and `readdatavalid` pipelining. It is the next generation of the HPS-side scratch memory in `soc_system`. Width, depth and maximum burst length are parameters. An optional post-reset clear sequencer is available.

## Interface
Parameters:
- `DATA_W`, 64: data width in bits; must be a multiple of 8.
- `ADDR_W`, 13: word address width; depth = 2^ADDR_W words.
- `BURST_W`, 4: burstcount width; maximum burst = 2^(BURST_W-1) beats.
- `INIT_FILE`, "soc_system_onchip_memory_burst.hex": power-up contents.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `chipselect`  in  1  slave select.
- `read`  in  1  read command.
- `write`  in  1  write command or write beat.
- `address`  in  ADDR_W  word address; sampled on the first beat only.
- `burstcount`  in  BURST_W  beats; sampled on the first beat; 0 is treated as 1.
- `byteenable`  in  DATA_W/8  per-beat byte lane enables.
- `writedata`  in  DATA_W  write data.
- `waitrequest`  out  1  command/beat stall.
- `readdata`  out  DATA_W  registered read data.
- `readdatavalid`  out  1  qualifies `readdata`, one beat per cycle.

## Operation
- The FSM has states IDLE, RD_BURST, WR_BURST and CLEAR. CLEAR exists only when the macro is defined.
- A command is accepted when `chipselect` is high and `waitrequest` is low.
- **IDLE** (`waitrequest` = 0):
  - If `write` is high: the beat is written at `address` using `byteenable`. If `burstcount` > 1, go to WR_BURST with remaining = burstcount-1 and next address = address+1.
  - Else if `read` is high: the RAM reads `address`. If `burstcount` > 1, go to RD_BURST with remaining = burstcount-1 and next address = address+1.
  - If `read` and `write` are both high, write wins and the read is dropped.
- **RD_BURST** (`waitrequest` = 1):
  - Issues one internal read per cycle at the next address, then increments the address.
  - Returns to IDLE in the cycle after the last address is issued.
  - Bus commands are ignored in this state.
- **WR_BURST** (`waitrequest` = 0):
  - Each cycle with `chipselect` and `write` high writes one beat at the next address and decrements remaining.
  - Cycles without `write` are idle gaps; the burst is held.
  - Returns to IDLE after the last beat.
  - `read` in this state is ignored.
- Address arithmetic is modulo 2^ADDR_W, so bursts wrap from the top word to word 0.
- Byte lanes whose `byteenable` bit is 0 are left unchanged.
- The RAM is a single port. A read and a write never occur in the same cycle, so no read-during-write case exists.

## Timing
- Reset values (`reset_n` low at an edge):
  - `waitrequest` = 1, `readdatavalid` = 0, `readdata` = 0.
  - FSM returns to IDLE (or CLEAR with the macro); counters are cleared.
- Without the macro, `waitrequest` falls in the first cycle after `reset_n` rises.
- Read latency is 1. For a read accepted at cycle T with burst n, beat k (k = 0..n-1) is valid at T+1+k.
- `readdatavalid` is high for exactly n consecutive cycles.
- `waitrequest` is high over T+1..T+n-1. The next command can be accepted at T+n.
- Back-to-back single reads therefore sustain one word per cycle.
- Writes take effect at the accepting edge. A read of the same word accepted in the next cycle returns the new data.
- Reset mid-burst:
  - The burst is abandoned and remaining beats are discarded.
  - `readdatavalid` drops at the reset edge.
  - RAM contents are retained, except when the clear sequence runs.

## Configuration
- Macro: `ONCHIP_MEM_CLEAR_ON_RESET_EN`.
- Defined:
  - After `reset_n` rises, the FSM enters CLEAR and writes zero to words 0..2^ADDR_W-1, one per cycle, all byte lanes.
  - `waitrequest` stays 1 for 2^ADDR_W cycles, then the FSM goes to IDLE.
  - INIT_FILE contents are overwritten.
  - A reset during CLEAR restarts the sequence at word 0.
- Not defined:
  - The CLEAR state and its counter are absent.
  - RAM keeps INIT_FILE contents and any prior writes across reset.

## Test plan
- Single write 0xDEADBEEF_01234567 to word 0x005 with byteenable 0xFF, then single read of 0x005 → `readdatavalid` one cycle after accept, with `readdata` = 0xDEADBEEF_01234567.
- Byte-lane write: write 0x11..11 to word 0x10 with byteenable 0xFF, then 0xAA..AA with byteenable 0x0F → read returns 0x11111111_AAAAAAAA.
- Write burst of 4 at 0x1FFE, with one idle gap after beat 2, data 1, 2, 3, 4 → words 0x1FFE, 0x1FFF, 0x0000 and 0x0001 hold 1, 2, 3, 4. Read burst 4 at 0x1FFE accepted at T → `readdatavalid` over T+1..T+4 carrying 1, 2, 3, 4, and `waitrequest` high over T+1..T+3.
- Three back-to-back single reads of 0x1, 0x2, 0x3 → three consecutive valid beats with no `waitrequest`.
- `reset_n` low during beat 2 of an 8-beat read → `readdatavalid` is 0 from the reset edge, no further beats, and memory is unchanged on re-read.
- With `ONCHIP_MEM_CLEAR_ON_RESET_EN`, ADDR_W = 4: write 0x55 to word 3, then pulse reset → `waitrequest` high for 16 cycles, and a read of word 3 then returns 0.

Source files
------------

// File: rtl/soc_system_onchip_memory_burst_if.sv
// Avalon-MM burst slave bus bundle for soc_system_onchip_memory_burst.
//   master : drives chipselect/read/write/address/burstcount/byteenable/writedata
//   slave  : drives waitrequest/readdata/readdatavalid
interface soc_system_onchip_memory_burst_if #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned BURST_W = 4
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic                chipselect;
    logic                read;
    logic                write;
    logic [ADDR_W-1:0]   address;
    logic [BURST_W-1:0]  burstcount;
    logic [BE_W-1:0]     byteenable;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output chipselect, read, write, address, burstcount, byteenable, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  chipselect, read, write, address, burstcount, byteenable, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/soc_system_onchip_memory_burst.sv
// On-chip single-port RAM behind an Avalon-MM burst slave.
// Read data is registered (latency 1) and qualified by readdatavalid; read
// bursts stall the bus with waitrequest while beats stream out, write bursts
// accept one beat per cycle with idle gaps allowed.
// Ports:
//   clk      : single rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : slave modport of soc_system_onchip_memory_burst_if
// Optional feature: define ONCHIP_MEM_CLEAR_ON_RESET_EN to zero every word
// after each reset (waitrequest held high for 2^ADDR_W cycles).
module soc_system_onchip_memory_burst #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned BURST_W   = 4,
    parameter              INIT_FILE = "soc_system_onchip_memory_burst.hex"
) (
    input  logic clk,
    input  logic reset_n,
    soc_system_onchip_memory_burst_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Elaboration guard on the parameter set.
    if (((DATA_W % 8) != 0) || ($bits(INIT_FILE) == 0)) begin : g_bad_params
        $error("soc_system_onchip_memory_burst: DATA_W must be a multiple of 8 and INIT_FILE named");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
`ifdef ONCHIP_MEM_CLEAR_ON_RESET_EN
        ,CLEAR   = 2'd3
`endif
    } state_t;

    // Preload image is bound to the array by the RAM macro flow.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0]  mem [DEPTH];

    state_t             state_q;
    logic [ADDR_W-1:0]  next_addr_q;
    logic [BURST_W-1:0] remaining_q;
    logic               wait_q;
    logic               rdv_q;
    logic [DATA_W-1:0]  rdata_q;
`ifdef ONCHIP_MEM_CLEAR_ON_RESET_EN
    logic [ADDR_W-1:0]  clr_addr_q;
`endif

    logic               accept;
    logic               multi_beat;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [BE_W-1:0]    wr_be;
    logic [DATA_W-1:0]  wr_data;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;

    assign accept     = bus.chipselect && !wait_q;
    // burstcount of 0 behaves as a single beat, so only >1 opens a burst.
    assign multi_beat = bus.burstcount > BURST_W'(1);

    // Single RAM port: decode which (if any) access happens this cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.address;
        wr_be   = bus.byteenable;
        wr_data = bus.writedata;
        rd_en   = 1'b0;
        rd_addr = bus.address;
        unique case (state_q)
            IDLE: begin
                if (accept && bus.write) begin
                    wr_en = 1'b1;
                end else if (accept && bus.read) begin
                    rd_en = 1'b1;
                end
            end
            RD_BURST: begin
                rd_en   = 1'b1;
                rd_addr = next_addr_q;
            end
            WR_BURST: begin
                wr_en   = bus.chipselect && bus.write;
                wr_addr = next_addr_q;
            end
`ifdef ONCHIP_MEM_CLEAR_ON_RESET_EN
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_addr_q;
                wr_be   = '1;
                wr_data = '0;
            end
`endif
            default: ;
        endcase
    end

    // RAM write port; writes are suppressed at a reset edge.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Burst FSM with registered bus outputs and read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
`ifdef ONCHIP_MEM_CLEAR_ON_RESET_EN
            state_q    <= CLEAR;
            clr_addr_q <= '0;
`else
            state_q    <= IDLE;
`endif
            next_addr_q <= '0;
            remaining_q <= '0;
            wait_q      <= 1'b1;
            rdv_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rdv_q <= rd_en;
            if (rd_en) begin
                rdata_q <= mem[rd_addr];
            end
            unique case (state_q)
                IDLE: begin
                    wait_q <= 1'b0;
                    if (accept && (bus.write || bus.read) && multi_beat) begin
                        state_q     <= bus.write ? WR_BURST : RD_BURST;
                        remaining_q <= bus.burstcount - BURST_W'(1);
                        next_addr_q <= bus.address + ADDR_W'(1);
                        // Only read bursts stall the bus.
                        wait_q      <= !bus.write;
                    end
                end
                RD_BURST: begin
                    next_addr_q <= next_addr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - BURST_W'(1);
                    if (remaining_q == BURST_W'(1)) begin
                        state_q <= IDLE;
                        wait_q  <= 1'b0;
                    end
                end
                WR_BURST: begin
                    if (bus.chipselect && bus.write) begin
                        next_addr_q <= next_addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - BURST_W'(1);
                        if (remaining_q == BURST_W'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
`ifdef ONCHIP_MEM_CLEAR_ON_RESET_EN
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    if (&clr_addr_q) begin
                        state_q <= IDLE;
                        wait_q  <= 1'b0;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.waitrequest   = wait_q;
    assign bus.readdatavalid = rdv_q;
    assign bus.readdata      = rdata_q;
endmodule
